// File: rtl/div_unit.sv
// Restoring radix-2 divider (signed/unsigned): DATA_WIDTH BUSY cycles, divide-by-zero goes straight to DONE.
// Result is held in DONE until out_ready; in_ready only in IDLE.
module div_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   input  logic                  is_signed,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] quotient,
   output logic [DATA_WIDTH-1:0] remainder,
   output logic                  div_zero
);

   localparam int CW = $clog2(DATA_WIDTH) + 1;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);

   logic [1:0]            state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] rem_q, rem_d;
   logic [DATA_WIDTH-1:0] quo_q, quo_d;
   logic [DATA_WIDTH-1:0] dvs_mag_q, dvs_mag_d;
   logic                  neg_q_q, neg_q_d;
   logic                  neg_r_q, neg_r_d;
   logic [DATA_WIDTH-1:0] quotient_q, quotient_d;
   logic [DATA_WIDTH-1:0] remainder_q, remainder_d;
   logic                  div_zero_q, div_zero_d;

   logic                  dvd_neg, dvs_neg;
   logic [DATA_WIDTH-1:0] dvd_mag, dvs_mag;
   logic [DATA_WIDTH:0]   diff;
   logic [DATA_WIDTH-1:0] rem_next, quo_next;

   always_comb begin
      dvd_neg = is_signed & dividend[DATA_WIDTH-1];
      dvs_neg = is_signed & divisor[DATA_WIDTH-1];
      dvd_mag = dvd_neg ? -dividend : dividend;
      dvs_mag = dvs_neg ? -divisor : divisor;
      // Partial remainder is DATA_WIDTH+1 bits wide so the trial subtract can go negative.
      diff     = {rem_q, quo_q[DATA_WIDTH-1]} - {1'b0, dvs_mag_q};
      rem_next = diff[DATA_WIDTH] ? {rem_q[DATA_WIDTH-2:0], quo_q[DATA_WIDTH-1]}
                                  : diff[DATA_WIDTH-1:0];
      quo_next = {quo_q[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_mag_d   = dvs_mag_q;
      neg_q_d     = neg_q_q;
      neg_r_d     = neg_r_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      div_zero_d  = div_zero_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               if (divisor == '0) begin
                  state_d     = ST_DONE;
                  quotient_d  = '1;
                  remainder_d = dividend;
                  div_zero_d  = 1'b1;
               end else begin
                  state_d    = ST_BUSY;
                  cnt_d      = '0;
                  rem_d      = '0;
                  quo_d      = dvd_mag;
                  dvs_mag_d  = dvs_mag;
                  neg_q_d    = dvd_neg ^ dvs_neg;
                  neg_r_d    = dvd_neg;
                  div_zero_d = 1'b0;
               end
            end
         end
         ST_BUSY: begin
            rem_d = rem_next;
            quo_d = quo_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
               state_d     = ST_DONE;
               quotient_d  = neg_q_q ? -quo_next : quo_next;
               remainder_d = neg_r_q ? -rem_next : rem_next;
               div_zero_d  = 1'b0;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_mag_q   <= '0;
         neg_q_q     <= 1'b0;
         neg_r_q     <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         div_zero_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_mag_q   <= dvs_mag_d;
         neg_q_q     <= neg_q_d;
         neg_r_q     <= neg_r_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         div_zero_q  <= div_zero_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, div-by-zero, backpressure, reset abort.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        is_signed;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_zero;

   int errors = 0;
   int checks = 0;
   int edges;
   logic [31:0] hold_q, hold_r;
   logic        stable;

   div_unit #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor), .is_signed(is_signed),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Drive a request at a negedge, count edges (accept edge = 1) until out_valid.
   // Operand inputs are scrambled after acceptance to show they are ignored.
   task automatic run_req(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int n);
      @(negedge clk);
      dividend  = a;
      divisor   = b;
      is_signed = s;
      in_valid  = 1'b1;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         in_valid  = 1'b0;
         dividend  = $urandom;
         divisor   = $urandom;
         is_signed = $urandom_range(0, 1);
         if (out_valid) break;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      dividend = '0; divisor = '0; is_signed = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_quotient", quotient, 32'd0);
      chk("rst_remainder", remainder, 32'd0);
      chk("rst_div_zero", {31'b0, div_zero}, 32'd0);
      rst = 1'b0;

      // 100 / 7 unsigned
      run_req(32'd100, 32'd7, 1'b0, edges);
      chk("u100_7_latency", edges, 32'd33);
      chk("u100_7_q", quotient, 32'd14);
      chk("u100_7_r", remainder, 32'd2);
      chk("u100_7_dz", {31'b0, div_zero}, 32'd0);
      chk("done_in_ready", {31'b0, in_ready}, 32'd0);
      // Consume while a new request is presented: it must not be taken that cycle.
      in_valid = 1'b1; dividend = 32'd9; divisor = 32'd3;
      consume();
      chk("consume_out_valid", {31'b0, out_valid}, 32'd0);
      chk("consume_in_ready", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b0;

      // -100 / 7 signed
      run_req(32'hFFFF_FF9C, 32'd7, 1'b1, edges);
      chk("sneg100_7_latency", edges, 32'd33);
      chk("sneg100_7_q", quotient, 32'hFFFF_FFF2);
      chk("sneg100_7_r", remainder, 32'hFFFF_FFFE);
      chk("sneg100_7_dz", {31'b0, div_zero}, 32'd0);
      consume();

      // 100 / -7 signed
      run_req(32'd100, 32'hFFFF_FFF9, 1'b1, edges);
      chk("s100_neg7_q", quotient, 32'hFFFF_FFF2);
      chk("s100_neg7_r", remainder, 32'd2);
      consume();

      // -100 / -7 signed
      run_req(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, edges);
      chk("sneg_neg_q", quotient, 32'd14);
      chk("sneg_neg_r", remainder, 32'hFFFF_FFFE);
      consume();

      // Divide by zero
      run_req(32'h1234_5678, 32'd0, 1'b0, edges);
      chk("dz_latency", edges, 32'd1);
      chk("dz_q", quotient, 32'hFFFF_FFFF);
      chk("dz_r", remainder, 32'h1234_5678);
      chk("dz_flag", {31'b0, div_zero}, 32'd1);
      consume();

      // Signed overflow and the same operands unsigned
      run_req(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, edges);
      chk("ovf_latency", edges, 32'd33);
      chk("ovf_q", quotient, 32'h8000_0000);
      chk("ovf_r", remainder, 32'd0);
      chk("ovf_dz", {31'b0, div_zero}, 32'd0);
      consume();
      run_req(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, edges);
      chk("uovf_q", quotient, 32'd0);
      chk("uovf_r", remainder, 32'h8000_0000);
      consume();

      // Divisor larger than dividend
      run_req(32'd7, 32'd100, 1'b0, edges);
      chk("u7_100_q", quotient, 32'd0);
      chk("u7_100_r", remainder, 32'd7);

      // Backpressure: result held for 10 cycles, new request ignored.
      hold_q = quotient; hold_r = remainder; stable = 1'b1;
      in_valid = 1'b1; dividend = 32'd50; divisor = 32'd5;
      repeat (10) begin
         @(posedge clk);
         @(negedge clk);
         if (quotient !== hold_q || remainder !== hold_r || in_ready !== 1'b0
             || out_valid !== 1'b1) stable = 1'b0;
      end
      in_valid = 1'b0;
      chk("bp_stable", {31'b0, stable}, 32'd1);
      chk("bp_q", quotient, 32'd0);
      consume();

      // Reset in the middle of BUSY
      @(negedge clk);
      dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (15) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
      chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
      chk("abort_q", quotient, 32'd0);
      chk("abort_r", remainder, 32'd0);
      chk("abort_dz", {31'b0, div_zero}, 32'd0);
      stable = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (out_valid !== 1'b0) stable = 1'b0;
      end
      chk("abort_no_result", {31'b0, stable}, 32'd1);

      run_req(32'hFFFF_FFFF, 32'd1, 1'b0, edges);
      chk("post_rst_latency", edges, 32'd33);
      chk("post_rst_q", quotient, 32'hFFFF_FFFF);
      chk("post_rst_r", remainder, 32'd0);
      consume();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
